// File: rtl/spi_master_multi_pkg.sv
// Shared types for the multi-mode SPI master: FSM state encoding, mode bit
// positions, and the sample/shift edge rule.
package spi_master_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TAIL
  } spiState_t;

  localparam int CPHA_BIT = 0;
  localparam int CPOL_BIT = 1;

  // A clock edge samples MISO when its parity matches CPHA, otherwise it shifts MOSI.
  function automatic logic isSampleEdge(input logic edgeLsb, input logic cphaBit);
    return edgeLsb == cphaBit;
  endfunction

endpackage

// File: rtl/spi_master_multi_shifter.sv
// W-bit shift register: parallel load, serial out on the leading end, serial
// capture on the trailing end, direction fixed by MSB_FIRST.
module spi_shifter
  import spi_master_multi_pkg::*;
#(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] loadData_i,
  input  logic         shift_i,
  input  logic         serIn_i,
  output logic         serOut_o,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = loadData_i;
    end else if (shift_i) begin
      data_d = (MSB_FIRST != 0) ? {data_q[W-2:0], serIn_i} : {serIn_i, data_q[W-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign serOut_o = (MSB_FIRST != 0) ? data_q[W-1] : data_q[0];
  assign data_o   = data_q;

endmodule

// File: rtl/spi_master_multi.sv
// Step-paced SPI master with runtime CPOL/CPHA, N chip selects and MSB/LSB order.
// Define SPI_MASTER_BURST_EN to keep CS asserted across back-to-back matching words.
module spi_master_multi
  import spi_master_multi_pkg::*;
#(
  parameter int W         = 8,
  parameter int N         = 1,
  parameter int MSB_FIRST = 1,
  localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          step,
  input  logic [W-1:0]  in,
  output logic          get,
  input  logic          empty,
  input  logic [SW-1:0] sel,
  input  logic          cpol,
  input  logic          cpha,
  output logic [W-1:0]  out,
  output logic          put,
  output logic [N-1:0]  spi_cs_n,
  output logic          spi_clock,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] LAST_EDGE = CW'(2 * W - 1);

  spiState_t     state_q;
  logic [CW-1:0] edgeCnt_q;
  logic [1:0]    mode_q;
  logic          get_q;
  logic          put_q;
  logic [W-1:0]  out_q;
  logic [N-1:0]  csN_q;
  logic          sclk_q;
  logic          mosi_q;

  logic [N-1:0]  csSel;
  logic          sampleEdge;
  logic          shiftNow;
  logic          loadNow;
  logic          burstOk;
  logic          firstBit;
  logic          serOut;
  logic [W-1:0]  rxWord;

  // Out-of-range selects leave every line deasserted but the word still runs.
  always_comb begin
    csSel = '1;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) csSel[i] = 1'b0;
    end
  end

`ifdef SPI_MASTER_BURST_EN
  logic [SW-1:0] sel_q;
  assign burstOk = !empty && (sel == sel_q) &&
                   (cpol == mode_q[CPOL_BIT]) && (cpha == mode_q[CPHA_BIT]);
`else
  assign burstOk = 1'b0;
`endif

  assign sampleEdge = isSampleEdge(edgeCnt_q[0], mode_q[CPHA_BIT]);
  assign shiftNow   = step && ((state_q == ST_LEAD) || (state_q == ST_SHIFT)) && sampleEdge;
  assign loadNow    = step && !empty &&
                      ((state_q == ST_IDLE) || ((state_q == ST_TAIL) && burstOk));
  assign firstBit   = (MSB_FIRST != 0) ? in[W-1] : in[0];

  spi_shifter #(.W(W), .MSB_FIRST(MSB_FIRST)) uShifter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (loadNow),
    .loadData_i (in),
    .shift_i    (shiftNow),
    .serIn_i    (spi_miso),
    .serOut_o   (serOut),
    .data_o     (rxWord)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      edgeCnt_q <= '0;
      mode_q    <= '0;
      get_q     <= 1'b0;
      put_q     <= 1'b0;
      out_q     <= '0;
      csN_q     <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      sel_q     <= '0;
`endif
    end else begin
      get_q <= 1'b0;
      put_q <= 1'b0;
      if (step) begin
        unique case (state_q)
          ST_IDLE: sclk_q <= mode_q[CPOL_BIT];
          ST_LEAD, ST_SHIFT: begin
            sclk_q <= ~sclk_q;
            if (!sampleEdge) mosi_q <= serOut;
            if (edgeCnt_q == LAST_EDGE) begin
              state_q <= ST_TAIL;
            end else begin
              edgeCnt_q <= edgeCnt_q + 1'b1;
              state_q   <= ST_SHIFT;
            end
          end
          ST_TAIL: begin
            put_q   <= 1'b1;
            out_q   <= rxWord;
            csN_q   <= '1;
            mosi_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
      // A load (fresh or burst) overrides whatever the step above scheduled.
      if (loadNow) begin
        get_q            <= 1'b1;
        mode_q[CPOL_BIT] <= cpol;
        mode_q[CPHA_BIT] <= cpha;
        csN_q            <= csSel;
        sclk_q           <= cpol;
        mosi_q           <= cpha ? 1'b0 : firstBit;
        edgeCnt_q        <= '0;
        state_q          <= ST_LEAD;
`ifdef SPI_MASTER_BURST_EN
        sel_q            <= sel;
`endif
      end
    end
  end

  assign get       = get_q;
  assign put       = put_q;
  assign out       = out_q;
  assign spi_cs_n  = csN_q;
  assign spi_clock = sclk_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Randomised bench for spi_master_multi: a step-count model predicts every
// output each cycle; directed words pin the model with literal expectations.
module tb_spi_master_multi;

  localparam int W   = 8;
  localparam int N   = 3;
  localparam int MSB = 1;
  localparam int SW  = 2;
`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]  word;
    logic [SW-1:0] sel;
    logic          cpol;
    logic          cpha;
  } req_t;

  req_t srcQ[$];

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          step  = 1'b0;
  logic          empty = 1'b1;
  logic          cpol  = 1'b0;
  logic          cpha  = 1'b0;
  logic [W-1:0]  inData = '0;
  logic [SW-1:0] sel   = '0;
  logic          get, put, spi_clock, spi_mosi, spi_miso;
  logic [W-1:0]  outData;
  logic [N-1:0]  csN;

  bit   loopback = 1'b1;
  logic misoRand = 1'b0;
  int   stepPct  = 100;
  int   emptyPct = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;
  assign spi_miso = loopback ? spi_mosi : misoRand;

  spi_master_multi #(.W(W), .N(N), .MSB_FIRST(MSB)) dut (
    .clock     (clock),
    .reset     (reset),
    .step      (step),
    .in        (inData),
    .get       (get),
    .empty     (empty),
    .sel       (sel),
    .cpol      (cpol),
    .cpha      (cpha),
    .out       (outData),
    .put       (put),
    .spi_cs_n  (csN),
    .spi_clock (spi_clock),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is "steps since load"; edges are steps 1..2W, put is step 2W+1.
  bit            mValid = 1'b0;
  bit            mActive = 1'b0;
  int            mK = 0;
  logic [W-1:0]  mWord = '0;
  logic [SW-1:0] mSel = '0;
  logic          mCpol = 1'b0;
  logic          mCpha = 1'b0;
  bit            rxBits [W];
  logic          eGet = 1'b0, ePut = 1'b0, eSclk = 1'b0;
  logic [W-1:0]  eOut = '0;
  logic [N-1:0]  eCs = '1;

  function automatic logic [N-1:0] csFor(input logic [SW-1:0] s);
    logic [N-1:0] c = '1;
    if (int'(s) < N) c[int'(s)] = 1'b0;
    return c;
  endfunction

  function automatic logic txBit(input logic [W-1:0] w, input int j);
    return (MSB != 0) ? w[W-1-j] : w[j];
  endfunction

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] r = '0;
    for (int j = 0; j < W; j++) begin
      if (MSB != 0) r[W-1-j] = rxBits[j];
      else          r[j]     = rxBits[j];
    end
    return r;
  endfunction

  task automatic modelLoad();
    mActive = 1'b1; mK = 0; mWord = inData; mSel = sel; mCpol = cpol; mCpha = cpha;
    eGet = 1'b1; eCs = csFor(sel); eSclk = cpol;
    for (int j = 0; j < W; j++) rxBits[j] = 1'b0;
  endtask

  // Observations of the DUT used by the directed literal checks.
  logic [W-1:0] mosiLog = '0, lastPut = '0, prevPut = '0;
  logic [N-1:0] csAtGet = '1;
  logic         sclkAtGet = 1'b0, prevSclk = 1'b0;
  int stepCtr = 0, stepsAtPut = 0, toggles = 0, togglesAtPut = 0;
  int csHighSteps = 0, gapAtGet = 0, putCount = 0;
  bit inXfer = 1'b0;

  always @(negedge clock) begin
    if (put === 1'b1) begin
      stepsAtPut = stepCtr; togglesAtPut = toggles; putCount++;
      prevPut = lastPut; lastPut = outData; inXfer = 1'b0;
    end
    if (get === 1'b1) begin
      mosiLog = '0; stepCtr = 0; toggles = 0; inXfer = 1'b1;
      csAtGet = csN; sclkAtGet = spi_clock; gapAtGet = csHighSteps; csHighSteps = 0;
    end else begin
      if (inXfer && spi_clock !== prevSclk) toggles++;
      if (csN === '1 && step) csHighSteps++;
    end
    if (step) stepCtr++;
    prevSclk = spi_clock;

    if (mValid) begin
      checkOutput("get", 32'(get), 32'(eGet));
      checkOutput("put", 32'(put), 32'(ePut));
      checkOutput("out", 32'(outData), 32'(eOut));
      checkOutput("cs_n", 32'(csN), 32'(eCs));
      checkOutput("sclk", 32'(spi_clock), 32'(eSclk));
      if (!mActive) checkOutput("mosiIdle", 32'(spi_mosi), 32'd0);
      if (reset && step && mActive && mK < 2 * W && (mK % 2) == int'(mCpha)) begin
        checkOutput("mosiBit", 32'(spi_mosi), 32'(txBit(mWord, mK / 2)));
        mosiLog = {mosiLog[W-2:0], spi_mosi};
      end
    end

    if (!reset) begin
      mValid = 1'b1; mActive = 1'b0; mK = 0;
      eGet = 1'b0; ePut = 1'b0; eOut = '0; eCs = '1; eSclk = 1'b0;
    end else begin
      eGet = 1'b0; ePut = 1'b0;
      if (step) begin
        if (mActive && mK < 2 * W) begin
          if ((mK % 2) == int'(mCpha)) rxBits[mK / 2] = spi_miso;
          mK++;
          eSclk = mCpol ^ logic'(mK % 2);
        end else if (mActive) begin
          ePut = 1'b1; eOut = assemble();
          if (BURST && !empty && sel == mSel && cpol == mCpol && cpha == mCpha) begin
            modelLoad();
          end else begin
            mActive = 1'b0; eCs = '1; eSclk = mCpol;
          end
        end else if (!empty) begin
          modelLoad();
        end
      end
    end
  end

  task automatic tick();
    bit holdEmpty;
    @(posedge clock);
    #1;
    if (get === 1'b1 && srcQ.size() > 0) void'(srcQ.pop_front());
    step      = ($urandom_range(99) < stepPct);
    misoRand  = 1'($urandom_range(1));
    holdEmpty = ($urandom_range(99) < emptyPct);
    if (srcQ.size() > 0 && !holdEmpty) begin
      empty = 1'b0; inData = srcQ[0].word; sel = srcQ[0].sel;
      cpol = srcQ[0].cpol; cpha = srcQ[0].cpha;
    end else begin
      empty = 1'b1; inData = W'($urandom); sel = SW'($urandom);
      cpol = 1'($urandom); cpha = 1'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] w, input logic [SW-1:0] s,
                               input logic pol, input logic pha);
    srcQ.push_back('{word: w, sel: s, cpol: pol, cpha: pha});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((srcQ.size() > 0 || mActive) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drainBudget", 32'(n < budget), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    int pc;
    int guard;
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rstGet", 32'(get), 32'd0);
    checkOutput("rstPut", 32'(put), 32'd0);
    checkOutput("rstOut", 32'(outData), 32'd0);
    checkOutput("rstCs", 32'(csN), 32'h7);
    checkOutput("rstSclk", 32'(spi_clock), 32'd0);
    checkOutput("rstMosi", 32'(spi_mosi), 32'd0);
    reset = 1'b1;
    tick();

    applyStimulus(8'h48, 2'd0, 1'b0, 1'b0);
    drain(200);
    checkOutput("m0Out", 32'(lastPut), 32'h48);
    checkOutput("m0MosiBits", 32'(mosiLog), 32'h48);
    checkOutput("m0PutStep", 32'(stepsAtPut), 32'd17);
    checkOutput("m0CsActive", 32'(csAtGet), 32'h6);
    checkOutput("m0CsAfter", 32'(csN), 32'h7);

    stepPct = 60;
    applyStimulus(8'hA5, 2'd1, 1'b1, 1'b1);
    drain(400);
    checkOutput("m3SclkStart", 32'(sclkAtGet), 32'd1);
    checkOutput("m3Edges", 32'(togglesAtPut), 32'd16);
    checkOutput("m3Out", 32'(lastPut), 32'hA5);
    checkOutput("m3CsActive", 32'(csAtGet), 32'h5);
    checkOutput("m3SclkIdle", 32'(spi_clock), 32'd1);

    stepPct = 100;
    applyStimulus(8'h00, 2'd2, 1'b0, 1'b0);
    drain(200);
    checkOutput("sel2Cs", 32'(csAtGet), 32'h3);
    checkOutput("sel2Out", 32'(lastPut), 32'h00);
    pc = putCount;
    applyStimulus(8'h3C, 2'd3, 1'b0, 1'b1);
    drain(200);
    checkOutput("sel3Cs", 32'(csAtGet), 32'h7);
    checkOutput("sel3PutSeen", 32'(putCount - pc), 32'd1);
    checkOutput("sel3Out", 32'(lastPut), 32'h3C);

    applyStimulus(8'h65, 2'd0, 1'b0, 1'b0);
    applyStimulus(8'h6C, 2'd0, 1'b0, 1'b0);
    drain(300);
    checkOutput("pairFirst", 32'(prevPut), 32'h65);
    checkOutput("pairSecond", 32'(lastPut), 32'h6C);
    checkOutput("pairCsGap", 32'(BURST ? (gapAtGet == 0) : (gapAtGet >= 1)), 32'd1);

    pc = putCount;
    applyStimulus(8'hC3, 2'd0, 1'b1, 1'b1);
    guard = 0;
    while (!(mActive && mK >= 6) && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("midWordReached", 32'(guard < 100), 32'd1);
    reset = 1'b0;
    tick();
    checkOutput("midRstCs", 32'(csN), 32'h7);
    checkOutput("midRstSclk", 32'(spi_clock), 32'd0);
    checkOutput("midRstPut", 32'(put), 32'd0);
    reset = 1'b1;
    repeat (40) tick();
    checkOutput("midRstNoPut", 32'(putCount - pc), 32'd0);

    loopback = 1'b0;
    emptyPct = 20;
    for (int g = 0; g < 16; g++) begin
      logic [SW-1:0] s  = SW'($urandom);
      logic          p0 = 1'($urandom);
      logic          p1 = 1'($urandom);
      stepPct = $urandom_range(30, 100);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        if ($urandom_range(1) == 0) applyStimulus(W'($urandom), s, p0, p1);
        else applyStimulus(W'($urandom), SW'($urandom), 1'($urandom), 1'($urandom));
      end
      drain(2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
